// File: rtl/crc32_stream_ctrl.sv
// Frame-level sequencer around a combinational CRC-32 (reflected 0xEDB88320) word engine.
// Accepts 32-bit words via valid/ready, owns the running CRC and word count, reports per frame.
module crc32_stream_ctrl #(
  parameter logic [31:0] INIT    = 32'hFFFFFFFF,
  parameter logic [31:0] XOROUT  = 32'hFFFFFFFF,
  parameter logic [31:0] RESIDUE = 32'hDEBB20E3,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             check_mode,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [31:0]      s_data,
  input  logic             s_last,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_crc,
  output logic             res_ok,
  output logic [CNT_W-1:0] res_words,
  output logic             busy,
  output logic             err_proto
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } stateT;

  stateT             state, nextState;
  logic [31:0]       crcReg;
  logic [CNT_W-1:0]  count;
  logic              mode;
  logic              errProto;
  logic              loadFrame;
  logic              accept;
  logic              errNext;

  // Byte 0 sits in data[7:0]; bits are consumed LSB first.
  function automatic logic [31:0] crc32Word(input logic [31:0] crc, input logic [31:0] data);
    logic [31:0] c;
    c = crc;
    for (int unsigned i = 0; i < 32; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ 32'hEDB88320;
      else                c = c >> 1;
    end
    return c;
  endfunction

  always_comb begin
    nextState = state;
    loadFrame = 1'b0;
    accept    = 1'b0;
    errNext   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          nextState = RUN;
          loadFrame = 1'b1;
        end
      end
      RUN: begin
        accept = s_valid;
        if (s_valid && s_last) nextState = DONE;
        if (start) errNext = 1'b1;
      end
      DONE: begin
        // Consuming the result and opening a new frame in one cycle is legal.
        if (res_ready) begin
          if (start) begin
            nextState = RUN;
            loadFrame = 1'b1;
          end else begin
            nextState = IDLE;
          end
        end else if (start) begin
          errNext = 1'b1;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      crcReg   <= INIT;
      count    <= '0;
      mode     <= 1'b0;
      errProto <= 1'b0;
    end else begin
      state    <= nextState;
      errProto <= errNext;
      if (loadFrame) begin
        crcReg <= INIT;
        count  <= '0;
        mode   <= check_mode;
      end else if (accept) begin
        crcReg <= crc32Word(crcReg, s_data);
        if (count != '1) count <= count + 1'b1;
      end
    end
  end

  assign s_ready   = (state == RUN);
  assign res_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign res_crc   = crcReg ^ XOROUT;
  assign res_ok    = mode && (crcReg == RESIDUE);
  assign res_words = count;
  assign err_proto = errProto;

endmodule

// File: tb/tb_crc32_stream_ctrl.sv
// Directed bench for crc32_stream_ctrl: a default instance plus a CNT_W=2 instance
// sharing the same stimulus; the small one is used for counter saturation.
module tb_crc32_stream_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        checkMode;
  logic        sValid;
  logic [31:0] sData;
  logic        sLast;
  logic        resReady;

  logic        sReady, resValid, resOk, busy, errProto;
  logic [31:0] resCrc;
  logic [15:0] resWords;

  logic        sReadyS, resValidS, resOkS, busyS, errProtoS;
  logic [31:0] resCrcS;
  logic [1:0]  resWordsS;

  int checks = 0;
  int errors = 0;

  crc32_stream_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .check_mode(checkMode),
    .s_valid(sValid), .s_ready(sReady), .s_data(sData), .s_last(sLast),
    .res_valid(resValid), .res_ready(resReady), .res_crc(resCrc), .res_ok(resOk),
    .res_words(resWords), .busy(busy), .err_proto(errProto)
  );

  crc32_stream_ctrl #(.CNT_W(2)) dutSmall (
    .clk(clk), .rst_n(rst_n), .start(start), .check_mode(checkMode),
    .s_valid(sValid), .s_ready(sReadyS), .s_data(sData), .s_last(sLast),
    .res_valid(resValidS), .res_ready(resReady), .res_crc(resCrcS), .res_ok(resOkS),
    .res_words(resWordsS), .busy(busyS), .err_proto(errProtoS)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Byte-serial reference CRC-32 update over one little-endian word.
  function automatic logic [31:0] modelCrc(input logic [31:0] crc, input logic [31:0] w);
    logic [31:0] c;
    logic [7:0]  b;
    c = crc;
    for (int k = 0; k < 4; k++) begin
      b = w[8*k +: 8];
      c = c ^ {24'h0, b};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  task automatic startFrame(input logic mode);
    start = 1'b1; checkMode = mode;
    @(negedge clk);
    start = 1'b0; checkMode = 1'b0;
  endtask

  task automatic sendWord(input logic [31:0] d, input logic last);
    int unsigned n;
    n = 0;
    sValid = 1'b1; sData = d; sLast = last;
    while (sReady !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sReady !== 1'b1) begin
      errors++;
      $display("FAIL handshake_timeout: s_ready=%b required 1", sReady);
    end
    @(negedge clk);
    sValid = 1'b0; sLast = 1'b0;
  endtask

  task automatic consume();
    resReady = 1'b1;
    @(negedge clk);
    resReady = 1'b0;
    checks++;
    if (resValid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL consume: res_valid=%b busy=%b required 0 0", resValid, busy);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (sReady !== 1'b0 || resValid !== 1'b0 || resOk !== 1'b0 || busy !== 1'b0 ||
        errProto !== 1'b0 || resCrc !== 32'h0 || resWords !== 16'h0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b vld=%b ok=%b busy=%b err=%b crc=%h words=%0d required all zero",
               sReady, resValid, resOk, busy, errProto, resCrc, resWords);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || resCrc !== 32'h0) begin
      errors++;
      $display("FAIL post_reset_idle: busy=%b crc=%h required 0 00000000", busy, resCrc);
    end
  endtask

  task automatic test_idle_valid();
    sValid = 1'b1; sData = 32'h12345678;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sReady !== 1'b0 || errProto !== 1'b0 || busy !== 1'b0 || resWords !== 16'h0) begin
      errors++;
      $display("FAIL idle_valid: rdy=%b err=%b busy=%b words=%0d required 0 0 0 0",
               sReady, errProto, busy, resWords);
    end
    sValid = 1'b0;
  endtask

  task automatic test_single_zero();
    startFrame(1'b0);
    checks++;
    if (sReady !== 1'b1 || resValid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL run_entry: rdy=%b vld=%b busy=%b required 1 0 1", sReady, resValid, busy);
    end
    sendWord(32'h00000000, 1'b1);
    checks++;
    if (resValid !== 1'b1 || resCrc !== 32'h2144DF1C || resWords !== 16'd1 ||
        resOk !== 1'b0 || sReady !== 1'b0) begin
      errors++;
      $display("FAIL single_zero: vld=%b crc=%h words=%0d ok=%b rdy=%b required 1 2144df1c 1 0 0",
               resValid, resCrc, resWords, resOk, sReady);
    end
    consume();
  endtask

  task automatic test_two_word();
    startFrame(1'b0);
    sendWord(32'h34333231, 1'b0);
    checks++;
    if (resValid !== 1'b0 || resWords !== 16'd1) begin
      errors++;
      $display("FAIL two_word_mid: vld=%b words=%0d required 0 1", resValid, resWords);
    end
    sendWord(32'h38373635, 1'b1);
    checks++;
    if (resValid !== 1'b1 || resCrc !== 32'h9AE0DAAF || resOk !== 1'b0 || resWords !== 16'd2) begin
      errors++;
      $display("FAIL two_word: vld=%b crc=%h ok=%b words=%0d required 1 9ae0daaf 0 2",
               resValid, resCrc, resOk, resWords);
    end
    consume();
  endtask

  task automatic test_check_mode();
    startFrame(1'b1);
    sendWord(32'h34333231, 1'b0);
    sendWord(32'h38373635, 1'b0);
    sendWord(32'h9AE0DAAF, 1'b1);
    checks++;
    if (resValid !== 1'b1 || resOk !== 1'b1 || resWords !== 16'd3 || resCrc !== 32'h2144DF1C) begin
      errors++;
      $display("FAIL check_good: vld=%b ok=%b words=%0d crc=%h required 1 1 3 2144df1c",
               resValid, resOk, resWords, resCrc);
    end
    consume();
    startFrame(1'b1);
    sendWord(32'h34333231, 1'b0);
    sendWord(32'h38373635, 1'b0);
    sendWord(32'h9AE0DAAE, 1'b1);
    checks++;
    if (resValid !== 1'b1 || resOk !== 1'b0 || resWords !== 16'd3) begin
      errors++;
      $display("FAIL check_bad: vld=%b ok=%b words=%0d required 1 0 3", resValid, resOk, resWords);
    end
    consume();
  endtask

  task automatic test_hold_and_restart();
    startFrame(1'b0);
    sendWord(32'h34333231, 1'b0);
    sendWord(32'h38373635, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (resValid !== 1'b1 || resCrc !== 32'h9AE0DAAF || resWords !== 16'd2 ||
          sReady !== 1'b0 || errProto !== 1'b0) begin
        errors++;
        $display("FAIL done_hold[%0d]: vld=%b crc=%h words=%0d rdy=%b err=%b required 1 9ae0daaf 2 0 0",
                 i, resValid, resCrc, resWords, sReady, errProto);
      end
    end
    startFrame(1'b0);
    checks++;
    if (errProto !== 1'b1 || resValid !== 1'b1 || resCrc !== 32'h9AE0DAAF) begin
      errors++;
      $display("FAIL done_start_err: err=%b vld=%b crc=%h required 1 1 9ae0daaf", errProto, resValid, resCrc);
    end
    @(negedge clk);
    checks++;
    if (errProto !== 1'b0 || resValid !== 1'b1) begin
      errors++;
      $display("FAIL err_pulse_width: err=%b vld=%b required 0 1", errProto, resValid);
    end
    start = 1'b1; resReady = 1'b1;
    @(negedge clk);
    start = 1'b0; resReady = 1'b0;
    checks++;
    if (resValid !== 1'b0 || sReady !== 1'b1 || errProto !== 1'b0 || resWords !== 16'd0) begin
      errors++;
      $display("FAIL direct_restart: vld=%b rdy=%b err=%b words=%0d required 0 1 0 0",
               resValid, sReady, errProto, resWords);
    end
    startFrame(1'b0);
    checks++;
    if (errProto !== 1'b1 || sReady !== 1'b1) begin
      errors++;
      $display("FAIL run_start_err: err=%b rdy=%b required 1 1", errProto, sReady);
    end
    sendWord(32'h00000000, 1'b1);
    checks++;
    if (resValid !== 1'b1 || resCrc !== 32'h2144DF1C || resWords !== 16'd1 || errProto !== 1'b0) begin
      errors++;
      $display("FAIL restart_frame: vld=%b crc=%h words=%0d err=%b required 1 2144df1c 1 0",
               resValid, resCrc, resWords, errProto);
    end
    consume();
  endtask

  task automatic test_reset_midframe();
    startFrame(1'b0);
    sendWord(32'h34333231, 1'b0);
    checks++;
    if (resWords !== 16'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: words=%0d busy=%b required 1 1", resWords, busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (resCrc !== 32'h0 || resWords !== 16'h0 || busy !== 1'b0 || sReady !== 1'b0 ||
        resValid !== 1'b0 || errProto !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: crc=%h words=%0d busy=%b rdy=%b vld=%b err=%b required 0 0 0 0 0 0",
               resCrc, resWords, busy, sReady, resValid, errProto);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    startFrame(1'b0);
    sendWord(32'h34333231, 1'b0);
    sendWord(32'h38373635, 1'b1);
    checks++;
    if (resValid !== 1'b1 || resCrc !== 32'h9AE0DAAF || resWords !== 16'd2) begin
      errors++;
      $display("FAIL after_reset_frame: vld=%b crc=%h words=%0d required 1 9ae0daaf 2",
               resValid, resCrc, resWords);
    end
    consume();
  endtask

  task automatic test_saturate_gaps();
    logic [31:0] w [6];
    logic [31:0] c;
    w[0] = 32'hDEADBEEF; w[1] = 32'h01234567; w[2] = 32'h89ABCDEF;
    w[3] = 32'hCAFEF00D; w[4] = 32'h0BADF00D;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 5; i++) c = modelCrc(c, w[i]);
    w[5] = c ^ 32'hFFFFFFFF;
    startFrame(1'b1);
    for (int i = 0; i < 6; i++) begin
      int unsigned gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < int'(gap); g++) @(negedge clk);
      if (i == 5) begin
        checks++;
        if (resCrcS !== w[5] || resCrc !== w[5] || resWordsS !== 2'd3) begin
          errors++;
          $display("FAIL running_crc: small=%h main=%h words=%0d required %h %h 3",
                   resCrcS, resCrc, resWordsS, w[5], w[5]);
        end
      end
      sendWord(w[i], i == 5);
    end
    checks++;
    if (resValidS !== 1'b1 || resWordsS !== 2'd3 || resOkS !== 1'b1 || resCrcS !== 32'h2144DF1C) begin
      errors++;
      $display("FAIL saturate_small: vld=%b words=%0d ok=%b crc=%h required 1 3 1 2144df1c",
               resValidS, resWordsS, resOkS, resCrcS);
    end
    checks++;
    if (resWords !== 16'd6 || resOk !== 1'b1) begin
      errors++;
      $display("FAIL count_main: words=%0d ok=%b required 6 1", resWords, resOk);
    end
    consume();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; checkMode = 1'b0; sValid = 1'b0;
    sData = '0; sLast = 1'b0; resReady = 1'b0;
    test_reset();
    test_idle_valid();
    test_single_zero();
    test_two_word();
    test_check_mode();
    test_hold_and_restart();
    test_reset_midframe();
    test_saturate_gaps();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
